sc_lane_spawner: RTL and testbench
==================================

Name: sc_lane_spawner

Overview:
- Consumes the 8-bit even random value from the game's random source and converts it into traffic for one road lane.
- Holds a LANE_WIDTH-bit occupancy row; 1 means a car occupies that column.
- On each movement tick the row shifts one column, and the block inserts cars and gaps of random length at the entry edge.
- lane_out drives the lane's display matrix row and the frog collision check.

Parameters:
- DATAWIDTH_BUS, 8, width of rnd_in
- LANE_WIDTH, 8, columns in the lane row
- MIN_GAP, 2, minimum empty columns between cars (1..15)
- MAX_LEN, 3, maximum car length in columns (1..4)
- DIRECTION, 0, 0 = cars enter at bit 0 and shift left; 1 = cars enter at bit LANE_WIDTH-1 and shift right

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  lane running; low freezes all state
- shift_tick  in  1  one-clock pulse per lane movement step
- rnd_in  in  DATAWIDTH_BUS  random value; bits 0 and 7 are always 0
- lane_out  out  LANE_WIDTH  occupancy row
- spawn_pulse  out  1  one-clock pulse when a new car's first column enters
- state_out  out  2  current FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - lane_out=0, spawn_pulse=0, state=GAP
  - gap_cnt=MIN_GAP, len_cnt=0
- All updates occur only when enable=1 and shift_tick=1 (a "step"). Otherwise registers hold and spawn_pulse=0.
- Step action:
  - lane_out shifts one column; the bit at the exit edge is discarded.
  - The entry bit is 1 in state CAR and 0 in state GAP.
- Derived values, computed from rnd_in at the sampling step:
  - gap_len = MIN_GAP + rnd_in[3:1], range MIN_GAP..MIN_GAP+7
  - car_len = min(1 + rnd_in[5:4], MAX_LEN)
  - Use 5-bit arithmetic internally; no overflow is possible.
- FSM states: GAP=2'd0, CAR=2'd1. State 2'd2 and 2'd3 are illegal and recover to GAP on the next step with gap_cnt=MIN_GAP.
- GAP state, on each step:
  - insert 0
  - if gap_cnt>1: gap_cnt--
  - if gap_cnt==1: sample rnd_in, load len_cnt=car_len, go to CAR
- CAR state, on each step:
  - insert 1
  - if this is the first CAR step (len_cnt==car_len as loaded, tracked by a first flag): spawn_pulse=1 in the following cycle, for one clock
  - if len_cnt>1: len_cnt--
  - if len_cnt==1: sample rnd_in, load gap_cnt=gap_len, go to GAP
- rnd_in is sampled only in the clock cycle of the transition step. Its value at other times is ignored.
- Latency:
  - lane_out reflects a step one clock after the shift_tick cycle.
  - spawn_pulse is coincident with that lane_out update.
- Back-to-back shift_tick on consecutive clocks: legal; each is a full step.
- enable deassert mid-car: the row and counters freeze. When re-enabled, the car continues with its remaining length; no truncation.
- Reset mid-operation: immediate clear; the first car appears MIN_GAP steps after release.

Optional Feature:
- Macro: SC_LANE_SPAWNER_STATS_EN
- Defined:
  - adds output car_count (8 bits, reset 0)
  - increments on each spawn_pulse and wraps 255→0
  - adds output max_gap_seen (4 bits) holding the largest rnd_in[3:1]+MIN_GAP sampled, saturating at 15
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared game package holds:
  - state encodings GAP/CAR
  - LANE_WIDTH default
  - the rnd field positions: GAP_LSB=1, GAP_MSB=3, LEN_LSB=4, LEN_MSB=5
- One sub-module, sc_lane_shiftreg: parameterised row register with shift enable, direction, serial entry bit and parallel output.
- The FSM and counters stay in the top module.

Test Plan:
- Reset with rnd_in=8'h00, MIN_GAP=2, DIRECTION=0, then 10 consecutive ticks:
  - steps 1-2 insert 0; step 3 inserts 1 (car_len=1); steps 4-5 insert 0
  - lane_out after 3 steps = 8'b0000_0001; after 5 steps = 8'b0000_0100
  - spawn_pulse exactly once per car
- Hold rnd_in=8'h3E: gap_len=9, car_len=min(4,3)=3. Check runs of exactly 3 ones separated by 9 zeros; spawn_pulse once per run.
- DIRECTION=1, rnd_in=8'h00: after 3 ticks lane_out=8'b1000_0000; shifts right on following ticks.
- Pulse enable=0 for 20 clocks mid-car with shift_tick active: lane_out and state_out unchanged. Re-enable: the car completes with its remaining length.
- Assert reset low asynchronously between clock edges mid-car: lane_out=0 and state_out=0 immediately, with no clock required.
- With SC_LANE_SPAWNER_STATS_EN defined: 256 spawns → car_count wraps to 0. With rnd_in=8'h0E and MIN_GAP=2: max_gap_seen=9.

Source files
------------

// File: rtl/sc_lane_spawner_pkg.sv
// Shared lane-spawner definitions: state encodings, lane default, rnd field positions.
package sc_lane_spawner_pkg;

  localparam int unsigned LANE_WIDTH_DEF = 8;

  localparam logic [1:0] GAP = 2'd0;
  localparam logic [1:0] CAR = 2'd1;

  localparam int unsigned GAP_LSB = 1;
  localparam int unsigned GAP_MSB = 3;
  localparam int unsigned LEN_LSB = 4;
  localparam int unsigned LEN_MSB = 5;

  function automatic logic [4:0] calc_gap_len(input logic [2:0] field, input int unsigned min_gap);
    return 5'(min_gap) + {2'b00, field};
  endfunction

  function automatic logic [4:0] calc_car_len(input logic [1:0] field, input int unsigned max_len);
    logic [4:0] len;
    len = 5'd1 + {3'b000, field};
    return (len > 5'(max_len)) ? 5'(max_len) : len;
  endfunction

endpackage

// File: rtl/sc_lane_spawner_if.sv
// Lane spawner handshake bundle; stats outputs exist only with SC_LANE_SPAWNER_STATS_EN.
interface sc_lane_spawner_if #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned LANE_WIDTH    = 8
);
  logic                     enable;
  logic                     shift_tick;
  logic [DATAWIDTH_BUS-1:0] rnd_in;
  logic [LANE_WIDTH-1:0]    lane_out;
  logic                     spawn_pulse;
  logic [1:0]               state_out;
`ifdef SC_LANE_SPAWNER_STATS_EN
  logic [7:0]               car_count;
  logic [3:0]               max_gap_seen;

  modport master (output enable, shift_tick, rnd_in,
                  input  lane_out, spawn_pulse, state_out, car_count, max_gap_seen);
  modport slave  (input  enable, shift_tick, rnd_in,
                  output lane_out, spawn_pulse, state_out, car_count, max_gap_seen);
`else
  modport master (output enable, shift_tick, rnd_in,
                  input  lane_out, spawn_pulse, state_out);
  modport slave  (input  enable, shift_tick, rnd_in,
                  output lane_out, spawn_pulse, state_out);
`endif
endinterface

// File: rtl/sc_lane_shiftreg.sv
// Lane occupancy row: shifts one column per enabled cycle, serial entry at the direction's edge.
module sc_lane_shiftreg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIRECTION = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             entry_bit,
  output logic [WIDTH-1:0] row
);

  logic [WIDTH-1:0] row_next;

  generate
    if (DIRECTION == 0) begin : g_left
      assign row_next = {row[WIDTH-2:0], entry_bit};
    end else begin : g_right
      assign row_next = {entry_bit, row[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row <= '0;
    end else if (shift_en) begin
      row <= row_next;
    end
  end

endmodule

// File: rtl/sc_lane_spawner.sv
// Road-lane traffic spawner: GAP/CAR FSM feeding a shifting occupancy row.
// Optional stats (car_count, max_gap_seen) enabled by defining SC_LANE_SPAWNER_STATS_EN.
module sc_lane_spawner
  import sc_lane_spawner_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned LANE_WIDTH    = LANE_WIDTH_DEF,
  parameter int unsigned MIN_GAP       = 2,
  parameter int unsigned MAX_LEN       = 3,
  parameter int unsigned DIRECTION     = 0
) (
  input  logic               clock,
  input  logic               reset,
  sc_lane_spawner_if.slave   bus
);

  logic [1:0] state;
  logic [4:0] gap_cnt;
  logic [4:0] len_cnt;
  logic       first;
  logic       spawn_q;
  logic       step;
  logic       entry_bit;
  logic [4:0] gap_len;
  logic [4:0] car_len;
  logic       unused_rnd;

  assign step      = bus.enable & bus.shift_tick;
  assign entry_bit = (state == CAR);
  assign gap_len   = calc_gap_len(bus.rnd_in[GAP_MSB:GAP_LSB], MIN_GAP);
  assign car_len   = calc_car_len(bus.rnd_in[LEN_MSB:LEN_LSB], MAX_LEN);
  assign unused_rnd = ^{bus.rnd_in[0], bus.rnd_in[DATAWIDTH_BUS-1:LEN_MSB+1]};

  sc_lane_shiftreg #(
    .WIDTH     (LANE_WIDTH),
    .DIRECTION (DIRECTION)
  ) u_row (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (step),
    .entry_bit (entry_bit),
    .row       (bus.lane_out)
  );

  // A zero gap_cnt is unreachable; treating it like 1 keeps the FSM from stalling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= GAP;
      gap_cnt <= 5'(MIN_GAP);
      len_cnt <= '0;
      first   <= 1'b0;
      spawn_q <= 1'b0;
    end else begin
      spawn_q <= 1'b0;
      if (step) begin
        case (state)
          GAP: begin
            if (gap_cnt > 5'd1) begin
              gap_cnt <= gap_cnt - 5'd1;
            end else begin
              len_cnt <= car_len;
              first   <= 1'b1;
              state   <= CAR;
            end
          end
          CAR: begin
            spawn_q <= first;
            first   <= 1'b0;
            if (len_cnt > 5'd1) begin
              len_cnt <= len_cnt - 5'd1;
            end else begin
              gap_cnt <= gap_len;
              state   <= GAP;
            end
          end
          default: begin
            state   <= GAP;
            gap_cnt <= 5'(MIN_GAP);
            first   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.spawn_pulse = spawn_q;
  assign bus.state_out   = state;

`ifdef SC_LANE_SPAWNER_STATS_EN
  logic [7:0] car_count;
  logic [3:0] max_gap_seen;

  // Counts on the first CAR step, so the count updates together with spawn_pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      car_count    <= '0;
      max_gap_seen <= '0;
    end else if (step && state == CAR) begin
      if (first) begin
        car_count <= car_count + 8'd1;
      end
      if (len_cnt <= 5'd1 && gap_len > {1'b0, max_gap_seen}) begin
        max_gap_seen <= (gap_len > 5'd15) ? 4'd15 : gap_len[3:0];
      end
    end
  end

  assign bus.car_count    = car_count;
  assign bus.max_gap_seen = max_gap_seen;
`endif

endmodule

// File: tb/tb_sc_lane_spawner.sv
// Directed bench for sc_lane_spawner: left- and right-shifting lanes, freeze, async reset, stats.
module tb_sc_lane_spawner;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   spawns0;
  int   spawns1;
  logic [7:0] exp0;
  logic [7:0] exp1;

  sc_lane_spawner_if #(.DATAWIDTH_BUS(8), .LANE_WIDTH(8)) i0 ();
  sc_lane_spawner_if #(.DATAWIDTH_BUS(8), .LANE_WIDTH(8)) i1 ();

  sc_lane_spawner #(
    .DATAWIDTH_BUS (8),
    .LANE_WIDTH    (8),
    .MIN_GAP       (2),
    .MAX_LEN       (3),
    .DIRECTION     (0)
  ) dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (i0)
  );

  sc_lane_spawner #(
    .DATAWIDTH_BUS (8),
    .LANE_WIDTH    (8),
    .MIN_GAP       (2),
    .MAX_LEN       (3),
    .DIRECTION     (1)
  ) dut1 (
    .clock (clk),
    .reset (rst_n),
    .bus   (i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n back-to-back steps on the left lane, each inserting bit_v; spawn expected on the first if new_car.
  task automatic steps0(input int n, input logic bit_v, input logic new_car);
    for (int k = 0; k < n; k++) begin
      i0.shift_tick = 1'b1;
      @(negedge clk);
      exp0 = {exp0[6:0], bit_v};
      chk("lane0", {24'd0, i0.lane_out}, {24'd0, exp0});
      chk("spawn0", {31'd0, i0.spawn_pulse}, {31'd0, (new_car && k == 0)});
      if (i0.spawn_pulse) spawns0++;
    end
  endtask

  task automatic steps1(input int n, input logic bit_v, input logic new_car);
    for (int k = 0; k < n; k++) begin
      i1.shift_tick = 1'b1;
      @(negedge clk);
      exp1 = {bit_v, exp1[7:1]};
      chk("lane1", {24'd0, i1.lane_out}, {24'd0, exp1});
      chk("spawn1", {31'd0, i1.spawn_pulse}, {31'd0, (new_car && k == 0)});
      if (i1.spawn_pulse) spawns1++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i0.shift_tick = 1'b0;
    i1.shift_tick = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp0    = '0;
    exp1    = '0;
    spawns0 = 0;
    spawns1 = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    spawns0 = 0;
    spawns1 = 0;
    exp0 = '0;
    exp1 = '0;
    rst_n = 1'b0;
    i0.enable = 1'b1;
    i0.shift_tick = 1'b0;
    i0.rnd_in = 8'h00;
    i1.enable = 1'b0;
    i1.shift_tick = 1'b0;
    i1.rnd_in = 8'h00;

    // Reset state
    #1;
    chk("rst_lane", {24'd0, i0.lane_out}, 32'h0);
    chk("rst_state", {30'd0, i0.state_out}, 32'h0);
    chk("rst_spawn", {31'd0, i0.spawn_pulse}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // rnd=00: gap 2, car 1, repeating every 3 steps
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    chk("t1_after3", {24'd0, i0.lane_out}, 32'h01);
    steps0(2, 1'b0, 1'b0);
    chk("t1_after5", {24'd0, i0.lane_out}, 32'h04);
    steps0(1, 1'b1, 1'b1);
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    steps0(1, 1'b0, 1'b0);
    chk("t1_after10", {24'd0, i0.lane_out}, 32'h92);
    chk("t1_spawns", spawns0, 3);
    chk("t1_state", {30'd0, i0.state_out}, 32'h0);

    // rnd=3E: runs of 3 ones separated by 9 zeros
    do_reset();
    i0.rnd_in = 8'h3E;
    steps0(2, 1'b0, 1'b0);
    steps0(3, 1'b1, 1'b1);
    steps0(9, 1'b0, 1'b0);
    steps0(3, 1'b1, 1'b1);
    steps0(9, 1'b0, 1'b0);
    steps0(3, 1'b1, 1'b1);
    chk("t2_spawns", spawns0, 3);
    chk("t2_state", {30'd0, i0.state_out}, 32'h0);

    // Freeze mid-car for 20 clocks with shift_tick held high
    do_reset();
    i0.rnd_in = 8'h3E;
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    chk("t3_pre_state", {30'd0, i0.state_out}, 32'h1);
    i0.enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_frz_lane", {24'd0, i0.lane_out}, 32'h01);
      chk("t3_frz_state", {30'd0, i0.state_out}, 32'h1);
      chk("t3_frz_spawn", {31'd0, i0.spawn_pulse}, 32'h0);
    end
    i0.enable = 1'b1;
    steps0(2, 1'b1, 1'b0);
    chk("t3_resume_lane", {24'd0, i0.lane_out}, 32'h07);
    chk("t3_resume_state", {30'd0, i0.state_out}, 32'h0);
    steps0(1, 1'b0, 1'b0);
    chk("t3_gap_lane", {24'd0, i0.lane_out}, 32'h0E);

    // Asynchronous reset between edges mid-car
    do_reset();
    i0.rnd_in = 8'h3E;
    steps0(2, 1'b0, 1'b0);
    steps0(2, 1'b1, 1'b1);
    chk("t4_pre_state", {30'd0, i0.state_out}, 32'h1);
    i0.shift_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_lane", {24'd0, i0.lane_out}, 32'h0);
    chk("t4_async_state", {30'd0, i0.state_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp0 = '0;
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    chk("t4_first_car", {24'd0, i0.lane_out}, 32'h01);

    // Right-shifting lane
    do_reset();
    i0.enable = 1'b0;
    i1.enable = 1'b1;
    i1.rnd_in = 8'h00;
    steps1(2, 1'b0, 1'b0);
    steps1(1, 1'b1, 1'b1);
    chk("t5_after3", {24'd0, i1.lane_out}, 32'h80);
    steps1(1, 1'b0, 1'b0);
    chk("t5_after4", {24'd0, i1.lane_out}, 32'h40);
    steps1(1, 1'b0, 1'b0);
    steps1(1, 1'b1, 1'b1);
    chk("t5_after6", {24'd0, i1.lane_out}, 32'h90);
    chk("t5_spawns", spawns1, 2);
    i1.shift_tick = 1'b0;
    i1.enable = 1'b0;
    i0.enable = 1'b1;

`ifdef SC_LANE_SPAWNER_STATS_EN
    do_reset();
    i0.rnd_in = 8'h00;
    chk("st_rst_count", {24'd0, i0.car_count}, 32'h0);
    chk("st_rst_max", {28'd0, i0.max_gap_seen}, 32'h0);
    for (int c = 0; c < 255; c++) begin
      steps0(2, 1'b0, 1'b0);
      steps0(1, 1'b1, 1'b1);
    end
    chk("st_count255", {24'd0, i0.car_count}, 32'hFF);
    chk("st_max2", {28'd0, i0.max_gap_seen}, 32'h2);
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    chk("st_count_wrap", {24'd0, i0.car_count}, 32'h0);
    i0.rnd_in = 8'h0E;
    steps0(2, 1'b0, 1'b0);
    steps0(1, 1'b1, 1'b1);
    chk("st_max9", {28'd0, i0.max_gap_seen}, 32'h9);
    chk("st_count1", {24'd0, i0.car_count}, 32'h1);
`endif

    i0.shift_tick = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
